// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared constants for the ID/EX -> MEM/WB control pipeline and its hazard unit.
// Control bundle bit positions, the bubble value and the ALU operand forwarding codes.
package ctrl_pkg;

    localparam int CTRL_ALUSRC    = 11;
    localparam int CTRL_MEMTOREG  = 10;
    localparam int CTRL_REGWRITE  = 9;
    localparam int CTRL_MEMREAD   = 8;
    localparam int CTRL_MEMWRITE  = 7;
    localparam int CTRL_BRANCH    = 6;
    localparam int CTRL_LUI       = 5;
    localparam int CTRL_AUIPC     = 4;
    localparam int CTRL_JAL       = 3;
    localparam int CTRL_JALR      = 2;
    localparam int CTRL_ALUOP_MSB = 1;
    localparam int CTRL_ALUOP_LSB = 0;

    // Reduced bundles carried by the later stages
    localparam int MCTRL_MEMTOREG = 3;
    localparam int MCTRL_REGWRITE = 2;
    localparam int MCTRL_MEMREAD  = 1;
    localparam int MCTRL_MEMWRITE = 0;
    localparam int WCTRL_MEMTOREG = 1;
    localparam int WCTRL_REGWRITE = 0;

    localparam logic [11:0] CTRL_BUBBLE = 12'b0000_0000_0000;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// Bundle between the ID stage / hazard consumers and the control pipeline.
// master = ID side driving the decoded instruction, slave = ctrl_pipe_hazard.
interface ctrl_pipe_hazard_if #(
    parameter int CTRL_W = 12,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              flush_ex;
    logic              stall;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_valid;
    logic [3:0]        mem_ctrl;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_valid;
    logic [1:0]        wb_ctrl;
    logic [REG_AW-1:0] wb_rd;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, flush_ex,
        input  stall, ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd,
        input  mem_valid, mem_ctrl, mem_rd, wb_valid, wb_ctrl, wb_rd, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, flush_ex,
        output stall, ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd,
        output mem_valid, mem_ctrl, mem_rd, wb_valid, wb_ctrl, wb_rd, fwd_a, fwd_b
    );
endinterface

// File: rtl/ctrl_pipe_hazard_hazard_detect.sv
// Combinational RAW hazard unit: stall request and ALU operand forwarding selects.
// CTRL_FWD_EN enables EX/MEM and MEM/WB forwarding; without it every RAW on EX/MEM stalls.
module hazard_detect
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
`ifdef CTRL_FWD_EN
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              wb_valid,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
`else
    input  logic              ex_regwrite,
`endif
    input  logic              flush_ex,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    // x0 is hardwired, so writes to it never create a dependency
    function automatic logic is_producer(input logic v, input logic w, input logic [REG_AW-1:0] rd);
        return v & w & (rd != {REG_AW{1'b0}});
    endfunction

    logic load_use_s;
    logic mem_prod_s;
    logic raw_stall_s;

    assign mem_prod_s = is_producer(mem_valid, mem_regwrite, mem_rd);
    assign load_use_s = ex_valid & ex_memread & (ex_rd != {REG_AW{1'b0}}) & id_valid &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2));

`ifdef CTRL_FWD_EN
    logic wb_prod_s;

    assign wb_prod_s   = is_producer(wb_valid, wb_regwrite, wb_rd);
    assign raw_stall_s = load_use_s;

    // Forward select per operand; the younger EX/MEM result wins over MEM/WB
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_prod_s && (mem_rd == ex_rs1)) begin
            fwd_a = FWD_MEM;
        end else if (wb_prod_s && (wb_rd == ex_rs1)) begin
            fwd_a = FWD_WB;
        end else begin
            fwd_a = FWD_RF;
        end
        if (mem_prod_s && (mem_rd == ex_rs2)) begin
            fwd_b = FWD_MEM;
        end else if (wb_prod_s && (wb_rd == ex_rs2)) begin
            fwd_b = FWD_WB;
        end else begin
            fwd_b = FWD_RF;
        end
    end
`else
    logic ex_prod_s;

    assign ex_prod_s   = is_producer(ex_valid, ex_regwrite, ex_rd);
    assign raw_stall_s = load_use_s | (id_valid &
                         ((ex_prod_s  & ((ex_rd  == id_rs1) | (ex_rd  == id_rs2))) |
                          (mem_prod_s & ((mem_rd == id_rs1) | (mem_rd == id_rs2)))));
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    // A flush discards the ID instruction anyway, so it suppresses any stall
    always_comb begin
        stall = 1'b0;
        if (flush_ex) begin
            stall = 1'b0;
        end else begin
            stall = raw_stall_s;
        end
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline registers ID/EX, EX/MEM, MEM/WB with bubble/flush handling.
// Build option CTRL_FWD_EN selects the forwarding hazard policy in hazard_detect.
module ctrl_pipe_hazard
    import ctrl_pkg::*;
#(
    parameter int CTRL_W = 12,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_pipe_hazard_if.slave  bus
);

    logic              ex_valid_r;
    logic [CTRL_W-1:0] ex_ctrl_r;
    logic [REG_AW-1:0] ex_rs1_r;
    logic [REG_AW-1:0] ex_rs2_r;
    logic [REG_AW-1:0] ex_rd_r;
    logic              mem_valid_r;
    logic [3:0]        mem_ctrl_r;
    logic [REG_AW-1:0] mem_rd_r;
    logic              wb_valid_r;
    logic [1:0]        wb_ctrl_r;
    logic [REG_AW-1:0] wb_rd_r;
    logic              stall_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
`ifdef CTRL_FWD_EN
        .ex_rs1       (ex_rs1_r),
        .ex_rs2       (ex_rs2_r),
        .wb_valid     (wb_valid_r),
        .wb_regwrite  (wb_ctrl_r[WCTRL_REGWRITE]),
        .wb_rd        (wb_rd_r),
`else
        .ex_regwrite  (ex_ctrl_r[CTRL_REGWRITE]),
`endif
        .flush_ex     (bus.flush_ex),
        .id_valid     (bus.id_valid),
        .id_rs1       (bus.id_rs1),
        .id_rs2       (bus.id_rs2),
        .ex_valid     (ex_valid_r),
        .ex_memread   (ex_ctrl_r[CTRL_MEMREAD]),
        .ex_rd        (ex_rd_r),
        .mem_valid    (mem_valid_r),
        .mem_regwrite (mem_ctrl_r[MCTRL_REGWRITE]),
        .mem_rd       (mem_rd_r),
        .stall        (stall_s),
        .fwd_a        (fwd_a_s),
        .fwd_b        (fwd_b_s)
    );

    // ID/EX register: flush or stall inserts a bubble, otherwise capture ID
    always_ff @(posedge clk) begin
        if (rst || bus.flush_ex || stall_s || !bus.id_valid) begin
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= CTRL_BUBBLE;
            ex_rs1_r   <= {REG_AW{1'b0}};
            ex_rs2_r   <= {REG_AW{1'b0}};
            ex_rd_r    <= {REG_AW{1'b0}};
        end else begin
            ex_valid_r <= 1'b1;
            ex_ctrl_r  <= bus.id_ctrl;
            ex_rs1_r   <= bus.id_rs1;
            ex_rs2_r   <= bus.id_rs2;
            ex_rd_r    <= bus.id_rd;
        end
    end

    // EX/MEM and MEM/WB always advance; only the memory/writeback bits travel on
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_r <= 1'b0;
            mem_ctrl_r  <= 4'b0000;
            mem_rd_r    <= {REG_AW{1'b0}};
            wb_valid_r  <= 1'b0;
            wb_ctrl_r   <= 2'b00;
            wb_rd_r     <= {REG_AW{1'b0}};
        end else begin
            mem_valid_r <= ex_valid_r;
            mem_ctrl_r  <= {ex_ctrl_r[CTRL_MEMTOREG], ex_ctrl_r[CTRL_REGWRITE],
                            ex_ctrl_r[CTRL_MEMREAD], ex_ctrl_r[CTRL_MEMWRITE]};
            mem_rd_r    <= ex_rd_r;
            wb_valid_r  <= mem_valid_r;
            wb_ctrl_r   <= {mem_ctrl_r[MCTRL_MEMTOREG], mem_ctrl_r[MCTRL_REGWRITE]};
            wb_rd_r     <= mem_rd_r;
        end
    end

    assign bus.stall     = stall_s;
    assign bus.fwd_a     = fwd_a_s;
    assign bus.fwd_b     = fwd_b_s;
    assign bus.ex_valid  = ex_valid_r;
    assign bus.ex_ctrl   = ex_ctrl_r;
    assign bus.ex_rs1    = ex_rs1_r;
    assign bus.ex_rs2    = ex_rs2_r;
    assign bus.ex_rd     = ex_rd_r;
    assign bus.mem_valid = mem_valid_r;
    assign bus.mem_ctrl  = mem_ctrl_r;
    assign bus.mem_rd    = mem_rd_r;
    assign bus.wb_valid  = wb_valid_r;
    assign bus.wb_ctrl   = wb_ctrl_r;
    assign bus.wb_rd     = wb_rd_r;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard; expectations follow the CTRL_FWD_EN setting of the build.
// The bench plays the IF/ID stage: it holds the ID instruction while stall is high.
module tb_ctrl_pipe_hazard;

    localparam logic [11:0] C_LW   = 12'b1111_0000_0000;
    localparam logic [11:0] C_ADDI = 12'b1010_0000_0010;
    localparam logic [11:0] C_ADD  = 12'b0010_0000_0010;

`ifdef CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ctrl_pipe_hazard_if bus ();

    ctrl_pipe_hazard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] c, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd);
        bus.id_valid = v;
        bus.id_ctrl  = c;
        bus.id_rs1   = r1;
        bus.id_rs2   = r2;
        bus.id_rd    = rd;
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 12'd0, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush_ex = 1'b0;
        drive(1'b1, C_ADDI, 5'd0, 5'd0, 5'd1);
        tick();
        tick();
        checks++; if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rs1, bus.ex_rs2, bus.ex_rd} !== 28'd0) begin
            errors++; $display("FAIL reset_ex: got %h want 0", {bus.ex_valid, bus.ex_ctrl, bus.ex_rs1, bus.ex_rs2, bus.ex_rd}); end
        checks++; if ({bus.mem_valid, bus.mem_ctrl, bus.mem_rd, bus.wb_valid, bus.wb_ctrl, bus.wb_rd} !== 18'd0) begin
            errors++; $display("FAIL reset_memwb: got %h want 0", {bus.mem_valid, bus.mem_ctrl, bus.mem_rd, bus.wb_valid, bus.wb_ctrl, bus.wb_rd}); end
        checks++; if ({bus.stall, bus.fwd_a, bus.fwd_b} !== 5'd0) begin
            errors++; $display("FAIL reset_hazard: got %b want 00000", {bus.stall, bus.fwd_a, bus.fwd_b}); end
        rst = 1'b0;
        tick();
        checks++; if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rd} !== {1'b1, C_ADDI, 5'd1}) begin
            errors++; $display("FAIL first_ex: got %h want %h", {bus.ex_valid, bus.ex_ctrl, bus.ex_rd}, {1'b1, C_ADDI, 5'd1}); end
        drive(1'b0, 12'd0, 5'd0, 5'd0, 5'd0);
        tick();
        checks++; if ({bus.mem_valid, bus.mem_ctrl, bus.mem_rd} !== {1'b1, 4'b0100, 5'd1}) begin
            errors++; $display("FAIL lat_mem: got %h want %h", {bus.mem_valid, bus.mem_ctrl, bus.mem_rd}, {1'b1, 4'b0100, 5'd1}); end
        tick();
        checks++; if ({bus.wb_valid, bus.wb_ctrl, bus.wb_rd} !== {1'b1, 2'b01, 5'd1}) begin
            errors++; $display("FAIL lat_wb: got %h want %h", {bus.wb_valid, bus.wb_ctrl, bus.wb_rd}, {1'b1, 2'b01, 5'd1}); end
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, C_ADD, 5'd5, 5'd7, 5'd6);
        checks++; if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
        tick();
        checks++; if ({bus.ex_valid, bus.ex_ctrl} !== 13'd0) begin
            errors++; $display("FAIL lu_bubble: got %h want 0", {bus.ex_valid, bus.ex_ctrl}); end
        checks++; if (bus.mem_ctrl !== 4'b1110) begin
            errors++; $display("FAIL lu_mem_ctrl: got %b want 1110", bus.mem_ctrl); end
        checks++; if (bus.stall !== !FWD) begin
            errors++; $display("FAIL lu_stall_2nd: got %b want %b", bus.stall, !FWD); end
        if (!FWD) begin
            tick();
            checks++; if (bus.stall !== 1'b0) begin
                errors++; $display("FAIL lu_stall_release: got %b want 0", bus.stall); end
        end
        tick();
        checks++; if ({bus.ex_ctrl, bus.ex_rs1, bus.ex_rs2, bus.ex_rd} !== {C_ADD, 5'd5, 5'd7, 5'd6}) begin
            errors++; $display("FAIL lu_add_ex: got %h want %h", {bus.ex_ctrl, bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, {C_ADD, 5'd5, 5'd7, 5'd6}); end
        checks++; if ({bus.fwd_a, bus.fwd_b} !== (FWD ? 4'b0100 : 4'b0000)) begin
            errors++; $display("FAIL lu_fwd: got %b want %b", {bus.fwd_a, bus.fwd_b}, (FWD ? 4'b0100 : 4'b0000)); end
        drain();
    endtask

    task automatic test_fwd_exmem();
        drive(1'b1, C_ADDI, 5'd1, 5'd0, 5'd3);
        tick();
        drive(1'b1, C_ADD, 5'd3, 5'd3, 5'd4);
        checks++; if (bus.stall !== !FWD) begin
            errors++; $display("FAIL exmem_stall: got %b want %b", bus.stall, !FWD); end
        if (!FWD) begin
            tick();
            checks++; if ({bus.stall, bus.ex_valid} !== 2'b10) begin
                errors++; $display("FAIL exmem_stall_2nd: got %b want 10", {bus.stall, bus.ex_valid}); end
            tick();
            checks++; if (bus.stall !== 1'b0) begin
                errors++; $display("FAIL exmem_release: got %b want 0", bus.stall); end
        end
        tick();
        checks++; if ({bus.ex_ctrl, bus.ex_rs1, bus.ex_rs2, bus.ex_rd} !== {C_ADD, 5'd3, 5'd3, 5'd4}) begin
            errors++; $display("FAIL exmem_sub_ex: got %h want %h", {bus.ex_ctrl, bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, {C_ADD, 5'd3, 5'd3, 5'd4}); end
        checks++; if ({bus.fwd_a, bus.fwd_b} !== (FWD ? 4'b1010 : 4'b0000)) begin
            errors++; $display("FAIL exmem_fwd: got %b want %b", {bus.fwd_a, bus.fwd_b}, (FWD ? 4'b1010 : 4'b0000)); end
        drain();
    endtask

    task automatic test_x0();
        drive(1'b1, C_ADDI, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd1);
        checks++; if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL x0_stall: got %b want 0", bus.stall); end
        tick();
        checks++; if ({bus.ex_rd, bus.fwd_a, bus.fwd_b} !== {5'd1, 4'b0000}) begin
            errors++; $display("FAIL x0_fwd: got %b want %b", {bus.ex_rd, bus.fwd_a, bus.fwd_b}, {5'd1, 4'b0000}); end
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5);
        tick();
        bus.flush_ex = 1'b1;
        drive(1'b1, C_ADD, 5'd5, 5'd5, 5'd6);
        checks++; if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
        tick();
        bus.flush_ex = 1'b0;
        checks++; if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rd} !== 18'd0) begin
            errors++; $display("FAIL flush_bubble: got %h want 0", {bus.ex_valid, bus.ex_ctrl, bus.ex_rd}); end
        checks++; if ({bus.mem_valid, bus.mem_ctrl, bus.mem_rd} !== {1'b1, 4'b1110, 5'd5}) begin
            errors++; $display("FAIL flush_mem: got %h want %h", {bus.mem_valid, bus.mem_ctrl, bus.mem_rd}, {1'b1, 4'b1110, 5'd5}); end
        drain();
    endtask

    task automatic test_double_producer();
        drive(1'b1, C_ADD, 5'd1, 5'd0, 5'd2);
        tick();
        drive(1'b1, C_ADD, 5'd1, 5'd0, 5'd2);
        tick();
        drive(1'b1, C_ADD, 5'd2, 5'd1, 5'd9);
        checks++; if (bus.stall !== !FWD) begin
            errors++; $display("FAIL dbl_stall: got %b want %b", bus.stall, !FWD); end
        if (!FWD) begin
            tick();
            tick();
            checks++; if (bus.stall !== 1'b0) begin
                errors++; $display("FAIL dbl_release: got %b want 0", bus.stall); end
        end
        tick();
        checks++; if ({bus.ex_rd, bus.fwd_a, bus.fwd_b} !== {5'd9, (FWD ? 4'b1000 : 4'b0000)}) begin
            errors++; $display("FAIL dbl_fwd: got %b want %b", {bus.ex_rd, bus.fwd_a, bus.fwd_b}, {5'd9, (FWD ? 4'b1000 : 4'b0000)}); end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, C_ADD, 5'd5, 5'd0, 5'd6);
        checks++; if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL rms_stall: got %b want 1", bus.stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.stall} !== 4'b0000) begin
            errors++; $display("FAIL rms_empty: got %b want 0000", {bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.stall}); end
        drain();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.flush_ex = 1'b0;
        test_reset();
        test_load_use();
        test_fwd_exmem();
        test_x0();
        test_flush();
        test_double_producer();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
